// File: rtl/shifter_pkg.sv
// Shared encodings for the operand-2 shifter.
//   AM_*  : addressing-mode select values on the AM input.
//   SH_*  : shift-type values taken from I[6:5] in shifted-register mode.
package shifter_pkg;

  localparam int unsigned DataWidth = 32;

  localparam logic [1:0] AM_ROT_IMM   = 2'b00;
  localparam logic [1:0] AM_REG       = 2'b01;
  localparam logic [1:0] AM_IMM       = 2'b10;
  localparam logic [1:0] AM_SHIFT_REG = 2'b11;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 32-bit barrel shifter with ARM shift semantics.
// An amount of zero selects the special encodings: LSL #0 passes the value and
// carry through, LSR/ASR #0 mean a shift by 32, ROR #0 is RRX.
// Ports:
//   val_i   : value to shift
//   amt_i   : shift amount 0..31
//   type_i  : shift type (SH_LSL/SH_LSR/SH_ASR/SH_ROR)
//   c_i     : carry-in (LSL #0 pass-through and RRX fill bit)
//   res_o   : shifted result
//   c_o     : shifter carry-out
module barrel_shifter
  import shifter_pkg::*;
(
  input  logic [31:0] val_i,
  input  logic [4:0]  amt_i,
  input  logic [1:0]  type_i,
  input  logic        c_i,
  output logic [31:0] res_o,
  output logic        c_o
);

  // One guard bit beyond the word catches the last bit shifted out.
  logic [32:0] ext;

  always_comb begin
    ext   = '0;
    res_o = val_i;
    c_o   = c_i;
    unique case (type_i)
      SH_LSL: begin
        if (amt_i != 5'd0) begin
          ext   = {1'b0, val_i} << amt_i;
          res_o = ext[31:0];
          c_o   = ext[32];
        end
      end
      SH_LSR: begin
        if (amt_i == 5'd0) begin
          res_o = '0;
          c_o   = val_i[31];
        end else begin
          ext   = {val_i, 1'b0} >> amt_i;
          res_o = ext[32:1];
          c_o   = ext[0];
        end
      end
      SH_ASR: begin
        if (amt_i == 5'd0) begin
          res_o = {32{val_i[31]}};
          c_o   = val_i[31];
        end else begin
          ext   = $signed({val_i, 1'b0}) >>> amt_i;
          res_o = ext[32:1];
          c_o   = ext[0];
        end
      end
      SH_ROR: begin
        if (amt_i == 5'd0) begin
          res_o = {c_i, val_i[31:1]};
          c_o   = val_i[0];
        end else begin
          res_o = (val_i >> amt_i) | (val_i << (6'd32 - {1'b0, amt_i}));
          // Last bit rotated out lands in bit 31.
          c_o   = res_o[31];
        end
      end
      default: begin
        res_o = val_i;
        c_o   = c_i;
      end
    endcase
  end

endmodule

// File: rtl/shifter.sv
// Operand-2 generator: selects rotated immediate, register, zero-extended
// immediate or shifted register, and registers the operand and carry-out.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (clears outputs)
//   Rm      : register operand
//   I       : 12-bit instruction immediate/shift field
//   AM      : addressing-mode select
//   C_in    : current carry flag
//   N_Shift : registered shifter operand
//   C_out   : registered shifter carry-out
module shifter
  import shifter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Rm,
  input  logic [11:0] I,
  input  logic [1:0]  AM,
  input  logic        C_in,
  output logic [31:0] N_Shift,
  output logic        C_out
);

  logic [31:0] bs_val;
  logic [4:0]  bs_amt;
  logic [1:0]  bs_type;
  logic [31:0] bs_res;
  logic        bs_c;

  logic [31:0] n_d, n_q;
  logic        c_d, c_q;

  // The single barrel shifter is shared: the rotated immediate borrows it as ROR.
  always_comb begin
    bs_val  = Rm;
    bs_amt  = I[11:7];
    bs_type = I[6:5];
    if (AM == AM_ROT_IMM) begin
      bs_val  = {24'b0, I[7:0]};
      bs_amt  = {I[11:8], 1'b0};
      bs_type = SH_ROR;
    end
  end

  barrel_shifter u_barrel_shifter (
    .val_i  (bs_val),
    .amt_i  (bs_amt),
    .type_i (bs_type),
    .c_i    (C_in),
    .res_o  (bs_res),
    .c_o    (bs_c)
  );

  always_comb begin
    n_d = Rm;
    c_d = C_in;
    case (AM)
      AM_ROT_IMM: begin
        // Rotate by zero must not fall into the shifter's RRX encoding.
        if (I[11:8] == 4'd0) begin
          n_d = {24'b0, I[7:0]};
          c_d = C_in;
        end else begin
          n_d = bs_res;
          c_d = bs_res[31];
        end
      end
      AM_REG: begin
        n_d = Rm;
        c_d = C_in;
      end
      AM_IMM: begin
        n_d = {20'b0, I};
        c_d = C_in;
      end
      AM_SHIFT_REG: begin
        n_d = bs_res;
        c_d = bs_c;
      end
      default: begin
        n_d = Rm;
        c_d = C_in;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= '0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_d;
      c_q <= c_d;
    end
  end

  assign N_Shift = n_q;
  assign C_out   = c_q;

endmodule

// File: tb/tb_shifter.sv
module tb_shifter;

  logic        clk;
  logic        rst;
  logic [31:0] Rm;
  logic [11:0] I;
  logic [1:0]  AM;
  logic        C_in;
  logic [31:0] N_Shift;
  logic        C_out;

  int errors = 0;
  int checks = 0;

  shifter dut (
    .clk     (clk),
    .rst     (rst),
    .Rm      (Rm),
    .I       (I),
    .AM      (AM),
    .C_in    (C_in),
    .N_Shift (N_Shift),
    .C_out   (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bit-at-a-time shifting straight from the operand rules.
  function automatic void ref_model(input logic [31:0] rm, input logic [11:0] imm,
                                    input logic [1:0] am, input logic cin,
                                    output logic [31:0] n, output logic c);
    int sh;
    int cnt;
    n = '0;
    c = cin;
    case (am)
      2'b00: begin
        cnt = 2 * int'(imm[11:8]);
        n = {24'b0, imm[7:0]};
        for (int k = 0; k < cnt; k++) n = {n[0], n[31:1]};
        c = (cnt == 0) ? cin : n[31];
      end
      2'b01: begin
        n = rm;
        c = cin;
      end
      2'b10: begin
        n = {20'b0, imm};
        c = cin;
      end
      default: begin
        sh = int'(imm[11:7]);
        n = rm;
        case (imm[6:5])
          2'b00: begin
            for (int k = 0; k < sh; k++) begin
              c = n[31];
              n = n << 1;
            end
          end
          2'b01: begin
            cnt = (sh == 0) ? 32 : sh;
            for (int k = 0; k < cnt; k++) begin
              c = n[0];
              n = n >> 1;
            end
          end
          2'b10: begin
            cnt = (sh == 0) ? 32 : sh;
            for (int k = 0; k < cnt; k++) begin
              c = n[0];
              n = {n[31], n[31:1]};
            end
          end
          default: begin
            if (sh == 0) begin
              c = rm[0];
              n = {cin, rm[31:1]};
            end else begin
              for (int k = 0; k < sh; k++) begin
                c = n[0];
                n = {n[0], n[31:1]};
              end
            end
          end
        endcase
      end
    endcase
  endfunction

  task automatic drive(input logic [31:0] rm, input logic [11:0] imm, input logic [1:0] am,
                       input logic cin);
    Rm   = rm;
    I    = imm;
    AM   = am;
    C_in = cin;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'hDEADBEEF, 12'hFFF, 2'b11, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (N_Shift !== 32'h0 || C_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: got N=%h C=%b, want N=00000000 C=0", N_Shift, C_out);
    end
    rst = 1'b0;
    drive(32'h0431FFEA, 12'h000, 2'b01, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (N_Shift !== 32'h0431FFEA || C_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got N=%h C=%b, want N=0431ffea C=0", N_Shift, C_out);
    end
  endtask

  task automatic test_modes();
    logic [1:0]  ams [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] exp [3] = '{32'h0C000000, 32'h0431FFEA, 32'h0000040C};
    for (int k = 0; k < 3; k++) begin
      drive(32'h0431FFEA, 12'h40C, ams[k], 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (N_Shift !== exp[k] || C_out !== 1'b0) begin
        errors++;
        $display("FAIL mode_am%0d: got N=%h C=%b, want N=%h C=0", ams[k], N_Shift, C_out,
                 exp[k]);
      end
    end
  endtask

  task automatic test_shift_reg();
    logic [11:0] imms [4] = '{12'h104, 12'h124, 12'h144, 12'h164};
    logic [31:0] exp  [4] = '{32'h10C7FFA8, 32'h010C7FFA, 32'h010C7FFA, 32'h810C7FFA};
    logic        expc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(32'h0431FFEA, imms[k], 2'b11, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (N_Shift !== exp[k] || C_out !== expc[k]) begin
        errors++;
        $display("FAIL shift_reg_%h: got N=%h C=%b, want N=%h C=%b", imms[k], N_Shift, C_out,
                 exp[k], expc[k]);
      end
    end
  endtask

  task automatic test_specials();
    logic [11:0] imms [4] = '{12'h020, 12'h040, 12'h060, 12'h000};
    logic [31:0] exp  [4] = '{32'h00000000, 32'hFFFFFFFF, 32'hC0000000, 32'h80000001};
    for (int k = 0; k < 4; k++) begin
      drive(32'h80000001, imms[k], 2'b11, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (N_Shift !== exp[k] || C_out !== 1'b1) begin
        errors++;
        $display("FAIL special_%h: got N=%h C=%b, want N=%h C=1", imms[k], N_Shift, C_out,
                 exp[k]);
      end
    end
  endtask

  task automatic test_rot_imm();
    drive(32'h0431FFEA, 12'h1FF, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (N_Shift !== 32'hC000003F || C_out !== 1'b1) begin
      errors++;
      $display("FAIL rot_imm_1ff: got N=%h C=%b, want N=c000003f C=1", N_Shift, C_out);
    end
    drive(32'h0431FFEA, 12'h0AB, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (N_Shift !== 32'h000000AB || C_out !== 1'b1) begin
      errors++;
      $display("FAIL rot_imm_0ab: got N=%h C=%b, want N=000000ab C=1", N_Shift, C_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] rm, en;
    logic [11:0] imm;
    logic [1:0]  am;
    logic        cin, ec;
    for (int k = 0; k < 300; k++) begin
      rm  = $urandom;
      imm = 12'($urandom);
      am  = 2'($urandom);
      cin = 1'($urandom);
      ref_model(rm, imm, am, cin, en, ec);
      drive(rm, imm, am, cin);
      @(posedge clk);
      #1;
      checks++;
      if (N_Shift !== en || C_out !== ec) begin
        errors++;
        $display("FAIL random_%0d (Rm=%h I=%h AM=%0d Cin=%b): got N=%h C=%b, want N=%h C=%b",
                 k, rm, imm, am, cin, N_Shift, C_out, en, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rm, en, prev_n;
    logic [11:0] imm;
    logic        cin, ec, prev_c;
    prev_n = N_Shift;
    prev_c = C_out;
    for (int k = 0; k < 16; k++) begin
      rm  = $urandom;
      imm = 12'($urandom);
      cin = 1'($urandom);
      ref_model(rm, imm, 2'(k), cin, en, ec);
      drive(rm, imm, 2'(k), cin);
      #2;
      // New inputs must not reach the outputs before the edge.
      checks++;
      if (N_Shift !== prev_n || C_out !== prev_c) begin
        errors++;
        $display("FAIL b2b_hold_%0d: got N=%h C=%b, want N=%h C=%b", k, N_Shift, C_out,
                 prev_n, prev_c);
      end
      @(posedge clk);
      #1;
      checks++;
      if (N_Shift !== en || C_out !== ec) begin
        errors++;
        $display("FAIL b2b_%0d: got N=%h C=%b, want N=%h C=%b", k, N_Shift, C_out, en, ec);
      end
      prev_n = en;
      prev_c = ec;
    end
    // Reset for a single edge in the middle of the stream.
    rst = 1'b1;
    drive(32'hFFFFFFFF, 12'h0AB, 2'b01, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (N_Shift !== 32'h0 || C_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reset: got N=%h C=%b, want N=00000000 C=0", N_Shift, C_out);
    end
    rst = 1'b0;
    drive(32'h0431FFEA, 12'h164, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (N_Shift !== 32'h810C7FFA || C_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_reset: got N=%h C=%b, want N=810c7ffa C=1", N_Shift, C_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 12'h0, 2'b00, 1'b0);
    #1;
    test_reset();
    test_modes();
    test_shift_reg();
    test_specials();
    test_rot_imm();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
